// File: rtl/day1_pkg.sv
// Shared definitions for the Day-1 rotation parser: nibble codes, parser states
// and the layout of one queued rotation record.
package day1_pkg;

    localparam logic [3:0] NIB_DIGIT_MAX = 4'h9;
    localparam logic [3:0] NIB_EOR       = 4'hA;
    localparam logic [3:0] NIB_EOS       = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A record is packed MSB to LSB as {ovf, dir_r, amount}.
    localparam int REC_META_W = 2;

    function automatic int rec_width(input int amt_w);
        return amt_w + REC_META_W;
    endfunction

    function automatic logic is_digit(input logic [3:0] nib);
        return nib <= NIB_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/day1_rotation_parser_if.sv
// Valid/ready rotation-record channel from the parser to the dial core.
interface day1_rotation_parser_if #(
    parameter int AMT_W = 16
) ();

    logic             rot_valid;
    logic             rot_ready;
    logic             rot_dir_r;
    logic [AMT_W-1:0] rot_amount;
    logic             rot_ovf;

    modport master (
        output rot_valid,
        output rot_dir_r,
        output rot_amount,
        output rot_ovf,
        input  rot_ready
    );

    modport slave (
        input  rot_valid,
        input  rot_dir_r,
        input  rot_amount,
        input  rot_ovf,
        output rot_ready
    );

endinterface

// File: rtl/day1_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is read straight out of the
// registered storage so a pushed word is visible the cycle after the push.
module day1_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // The extra MSB separates full from empty when the index bits match.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers define which entries
    // are live, and the head is forced to zero while the FIFO is empty.
    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/day1_rotation_parser.sv
// Day-1 front end: turns a nibble stream of decimal digits and terminators into
// {direction, amount, overflow} records queued towards the dial core.
module day1_rotation_parser
    import day1_pkg::*;
#(
    parameter int AMT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 8
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic [3:0]             data_in,
    input  logic                   dir_r,
    day1_rotation_parser_if.master rot,
    output logic                   stream_done,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int               REC_W   = rec_width(AMT_W);
    localparam logic [AMT_W-1:0] AMT_MAX = '1;

    state_t             state;
    state_t             state_next;
    logic [AMT_W-1:0]   acc;
    logic [AMT_W-1:0]   acc_next;
    logic               ovf;
    logic               ovf_next;
    logic               dir;
    logic               dir_next;
    logic               push_req;

    logic [AMT_W-1:0]   acc_base;
    logic [AMT_W+3:0]   acc_wide;
    logic               acc_sat;

    logic [REC_W-1:0]   fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               drop;

    // A first digit restarts from zero; later digits extend the running value.
    assign acc_base = (state == ST_ACCUM) ? acc : '0;
    assign acc_wide = ({4'b0000, acc_base} << 3) + ({4'b0000, acc_base} << 1)
                    + (AMT_W+4)'(data_in);
    assign acc_sat  = |acc_wide[AMT_W+3:AMT_W];

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        ovf_next   = ovf;
        dir_next   = dir;
        push_req   = 1'b0;

        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (is_digit(data_in)) begin
                    acc_next   = acc_sat ? AMT_MAX : acc_wide[AMT_W-1:0];
                    ovf_next   = ((state == ST_ACCUM) && ovf) || acc_sat;
                    dir_next   = (state == ST_IDLE) ? dir_r : dir;
                    state_next = ST_ACCUM;
                end else if (data_in == NIB_EOR) begin
                    push_req   = (state == ST_ACCUM);
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = ST_IDLE;
                end else if (data_in == NIB_EOS) begin
                    push_req   = (state == ST_ACCUM);
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            dir   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            ovf   <= ovf_next;
            dir   <= dir_next;
        end
    end

    // A full FIFO still takes the record when the head leaves in the same cycle.
    assign pop  = rot.rot_valid && rot.rot_ready;
    assign drop = push_req && fifo_full && !pop;

    day1_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .push      (push_req),
        .push_data ({ovf, dir, acc}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rot.rot_valid = !fifo_empty;
    assign {rot.rot_ovf, rot.rot_dir_r, rot.rot_amount} = fifo_head;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            drop_cnt    <= '0;
            stream_done <= 1'b0;
        end else begin
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
            if ((state == ST_DONE) && fifo_empty) stream_done <= 1'b1;
        end
    end

endmodule
